// File: rtl/fp_mul_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_arbiter
// Description : Round-robin sharing of one fixed-latency FP multiply pipeline
//               among N_REQ requesters, with tag-based result routing,
//               per-requester outstanding caps and misalignment detection.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_arbiter #(
    parameter int N_REQ           = 4,
    parameter int MUL_LATENCY     = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [32*N_REQ-1:0]  req_a,
    input  logic [32*N_REQ-1:0]  req_b,
    input  logic [3*N_REQ-1:0]   req_rm,
    output logic                 mul_valid_in,
    output logic [31:0]          mul_in1,
    output logic [31:0]          mul_in2,
    output logic [2:0]           mul_rm,
    input  logic                 mul_valid_out,
    input  logic [31:0]          mul_out,
    input  logic [3:0]           mul_flags,
    output logic [N_REQ-1:0]     resp_valid,
    output logic [31:0]          resp_data,
    output logic [3:0]           resp_flags,
    output logic                 busy,
    output logic                 tag_error
);

    localparam int c_IDW = $clog2(N_REQ);
    localparam int c_CW  = $clog2(MAX_OUTSTANDING + 1);

    // Arbitration state and outstanding counters
    logic [c_IDW-1:0] last_grant_q;
    logic [c_CW-1:0]  cnt_q [N_REQ];

    // Issue register feeding the pipeline
    logic             iss_valid_q;
    logic [31:0]      iss_a_q;
    logic [31:0]      iss_b_q;
    logic [2:0]       iss_rm_q;
    logic [c_IDW-1:0] iss_id_q;

    // Owner tags travelling alongside the pipeline; entry = {valid, id}
    logic [c_IDW:0]   tag_q [MUL_LATENCY];

    // Response register
    logic [N_REQ-1:0] resp_valid_q;
    logic [31:0]      resp_data_q;
    logic [3:0]       resp_flags_q;
    logic             tag_error_q;

    logic [N_REQ-1:0] w_elig;
    logic [N_REQ-1:0] w_ready;
    logic [c_IDW-1:0] w_gnt_id;
    logic             w_accept;
    int               w_idx;
    logic             w_head_v;
    logic [c_IDW-1:0] w_head_id;
    logic             w_tag_any;

    // Eligibility: a slot freed by a retiring response is reusable the same cycle
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_elig[i] = req_valid[i] &&
                        ((cnt_q[i] < c_CW'(MAX_OUTSTANDING)) || resp_valid_q[i]);
        end
    end

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_ready  = '0;
        w_gnt_id = '0;
        w_accept = 1'b0;
        w_idx    = 0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = (int'(last_grant_q) + 1 + k) % N_REQ;
            if (!w_accept && w_elig[w_idx]) begin
                w_accept       = 1'b1;
                w_ready[w_idx] = 1'b1;
                w_gnt_id       = c_IDW'(w_idx);
            end
        end
    end

    // Head of the tag line and any-tag-valid summary for busy
    always_comb begin
        w_head_v  = tag_q[MUL_LATENCY-1][c_IDW];
        w_head_id = tag_q[MUL_LATENCY-1][c_IDW-1:0];
        w_tag_any = 1'b0;
        for (int k = 0; k < MUL_LATENCY; k++) begin
            w_tag_any = w_tag_any | tag_q[k][c_IDW];
        end
    end

    // Issue register: capture the granted operands, hold data when idle
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid_q  <= 1'b0;
            iss_a_q      <= '0;
            iss_b_q      <= '0;
            iss_rm_q     <= '0;
            iss_id_q     <= '0;
            last_grant_q <= '0;
        end else begin
            iss_valid_q <= w_accept;
            if (w_accept) begin
                iss_a_q      <= req_a[32*int'(w_gnt_id) +: 32];
                iss_b_q      <= req_b[32*int'(w_gnt_id) +: 32];
                iss_rm_q     <= req_rm[3*int'(w_gnt_id) +: 3];
                iss_id_q     <= w_gnt_id;
                last_grant_q <= w_gnt_id;
            end
        end
    end

    // Tag shift register advances every cycle in lockstep with the pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < MUL_LATENCY; k++) tag_q[k] <= '0;
        end else begin
            tag_q[0] <= {iss_valid_q, iss_id_q};
            for (int k = 1; k < MUL_LATENCY; k++) tag_q[k] <= tag_q[k-1];
        end
    end

    // Response register and sticky alignment check against the pipeline strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_flags_q <= '0;
            tag_error_q  <= 1'b0;
        end else begin
            if (w_head_v) begin
                resp_valid_q <= N_REQ'(1) << w_head_id;
                resp_data_q  <= mul_out;
                resp_flags_q <= mul_flags;
            end else begin
                resp_valid_q <= '0;
            end
            if (mul_valid_out != w_head_v) tag_error_q <= 1'b1;
        end
    end

    // Outstanding counters: +1 on accept, -1 on response, unchanged on both
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (w_ready[i] && !resp_valid_q[i]) cnt_q[i] <= cnt_q[i] + 1'b1;
                else if (!w_ready[i] && resp_valid_q[i]) cnt_q[i] <= cnt_q[i] - 1'b1;
            end
        end
    end

    assign req_ready    = w_ready;
    assign mul_valid_in = iss_valid_q;
    assign mul_in1      = iss_a_q;
    assign mul_in2      = iss_b_q;
    assign mul_rm       = iss_rm_q;
    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_flags   = resp_flags_q;
    assign tag_error    = tag_error_q;
    assign busy         = iss_valid_q | w_tag_any | (|resp_valid_q);

endmodule
`default_nettype wire

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Shares one fp_multiply_pipeline instance among N_REQ requesters.
- Grants requests round-robin and issues at most one operation per cycle into the pipeline, which has fixed latency and no stall.
- Tracks the owner of each in-flight operation in a tag shift register and routes each result, with its IEEE flags, back to the owning requester.
- Caps outstanding operations per requester and detects loss of tag/pipeline alignment.

Parameters:
N_REQ, 4, number of requesters (2..8)
MUL_LATENCY, 4, cycles from mul_valid_in to mul_valid_out of the multiply pipeline
MAX_OUTSTANDING, 4, maximum in-flight operations per requester (1..MUL_LATENCY+2)

Ports:
clk  in  1  clock
rst  in  1  reset
req_valid  in  N_REQ  per-requester request valid
req_ready  out  N_REQ  per-requester accept (one-hot or zero)
req_a  in  32*N_REQ  operand A, requester i at [32i+31:32i]
req_b  in  32*N_REQ  operand B
req_rm  in  3*N_REQ  rounding mode (RNE/RTZ/RDN/RUP/RMM encoding)
mul_valid_in  out  1  issue strobe to pipeline
mul_in1  out  32  operand A to pipeline
mul_in2  out  32  operand B to pipeline
mul_rm  out  3  rounding mode to pipeline
mul_valid_out  in  1  pipeline result valid
mul_out  in  32  pipeline result
mul_flags  in  4  {overflow, underflow, inexact, invalid_operation} from pipeline
resp_valid  out  N_REQ  one-hot result strobe
resp_data  out  32  result, shared across requesters
resp_flags  out  4  flags, same order as mul_flags
busy  out  1  any operation in flight
tag_error  out  1  sticky misalignment flag

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0, round-robin pointer 0, all counters 0, tag register cleared.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUTSTANDING.
- Arbitration is combinational and round-robin:
  - Search starts at index (last_grant+1) mod N_REQ.
  - The first eligible requester gets req_ready[i]=1.
  - Ready may depend on valid.
  - last_grant updates only on an accepted transfer (valid&ready).
- Issue register: on accept at cycle T, operands, rm and owner ID are registered. At T+1: mul_valid_in=1 with mul_in1/mul_in2/mul_rm and the tag entering the tag shift register. With no accept, mul_valid_in=0 and the data outputs hold their previous value.
- Tag shift register is MUL_LATENCY deep, entry = {valid, id}. It shifts every cycle with no enable, and the head aligns with mul_valid_out.
- Response register: at cycle T+1+MUL_LATENCY (head tag valid), the next cycle drives:
  - resp_valid[id]=1
  - resp_data=mul_out
  - resp_flags=mul_flags
- Otherwise resp_valid=0 and data/flags hold.
- Total request-to-response latency is MUL_LATENCY+2 (6 by default). Responses have no backpressure; requesters must sink every strobe.
- Outstanding counters:
  - Increment on accept; decrement when resp_valid[i] asserts.
  - Same requester accept and retire in the same cycle: counter unchanged.
  - Counter never exceeds MAX_OUTSTANDING; req_ready is withheld at the cap.
- busy = issue register valid OR any tag valid OR any resp_valid.
- tag_error:
  - Set when mul_valid_out != head tag valid. Sticky until rst.
  - On mismatch, a response is still driven when the head tag is valid, using the tag's id.
  - A mul_valid_out with no valid tag is dropped.
- Throughput: one accept per cycle sustained. With N_REQ active requesters under the cap, each is granted every N_REQ cycles.
- Reset mid-operation: in-flight tags and counters are cleared and no responses are emitted for pre-reset requests. The pipeline must share rst so that no stale mul_valid_out arrives; if one does, tag_error sets.
- Operands and rm pass through bit-exact; no arithmetic is performed in this block.

Test Plan:
- Single op: rst, then req_valid[0]=1 with a=0x3FC00000, b=0x40000000, rm=RNE at cycle 10. Required: req_ready[0]=1 at cycle 10; mul_valid_in at cycle 11; with a behavioural pipeline model of latency 4, resp_valid=0001 at cycle 16 with resp_data=0x40400000, flags=0000.
- Round-robin fairness: all 4 requesters hold req_valid=1 continuously. Required: grant order 1,2,3,0,1,... after reset (pointer 0); one accept per cycle; each requester receives responses in issue order.
- Outstanding cap: MAX_OUTSTANDING=2, only requester 2 valid, continuously. Required: two accepts, then req_ready[2]=0 until its first resp_valid; accept resumes that same cycle, and the counter never reads 3.
- Flag routing: requester 3 issues 0x7F800000 x 0x00000000. Required: resp_valid[3] with the pipeline's 0x7FC00000 and resp_flags=0001; no other resp_valid bit asserts.
- Misalignment: force mul_valid_out=1 for one cycle with no op in flight. Required: tag_error=1 next cycle, stays 1 until rst, and no resp_valid.
- Reset mid-flight: 3 ops issued, rst pulsed 2 cycles later. Required: all outputs 0 the cycle after rst, no responses for the flushed ops, and counters at 0 so that a new request is accepted immediately.
